// File: rtl/ula_pkg.sv
// ula_pkg - shared types for the multi-cycle ALU.
//   ula_op_t    : 4-bit op codes (3-bit legacy ULA codes plus shifts, MUL, DIVU)
//   ula_state_t : control FSM states
//   is_iterative: true for ops that take the WIDTH-step iterative path
package ula_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_NOR  = 4'd3,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIVU = 4'd12
  } ula_op_t;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} ula_state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// ula_multiciclo_if - request/result bundle between the datapath control and the ALU.
//   master: drives start, ULAControl, ScrA, ScrB; receives results, flags, busy, done
//   slave : the ALU side
interface ula_multiciclo_if #(parameter int WIDTH = 8);

  logic             start;
  logic [3:0]       ULAControl;
  logic [WIDTH-1:0] ScrA;
  logic [WIDTH-1:0] ScrB;
  logic [WIDTH-1:0] ULAResult;
  logic [WIDTH-1:0] ULAHi;
  logic             Z;
  logic             C;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, ULAControl, ScrA, ScrB,
    input  ULAResult, ULAHi, Z, C, V, busy, done
  );

  modport slave (
    input  start, ULAControl, ScrA, ScrB,
    output ULAResult, ULAHi, Z, C, V, busy, done
  );

endinterface

// File: rtl/ula_core.sv
// ula_core - combinational single-cycle ALU operations and ADD/SUB flags.
//   i_op     : op code (MUL/DIVU and unused codes give result 0)
//   i_a, i_b : latched operands; shift amount is the low log2(WIDTH) bits of i_b
//   o_result : operation result, mod 2^WIDTH
//   o_c      : ADD carry-out, SUB no-borrow; 0 otherwise
//   o_v      : ADD/SUB signed overflow; 0 otherwise
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_c,
  output logic             o_v
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] w_sh;
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;

  always_comb begin
    w_sh  = i_b[SW-1:0];
    w_add = {1'b0, i_a} + {1'b0, i_b};
    // Carry out of A + ~B + 1 is the unsigned A >= B indication.
    w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    o_result = '0;
    o_c      = 1'b0;
    o_v      = 1'b0;
    case (i_op)
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_NOR: o_result = ~(i_a | i_b);
      OP_ADD: begin
        o_result = w_add[WIDTH-1:0];
        o_c      = w_add[WIDTH];
        o_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        o_result = w_sub[WIDTH-1:0];
        o_c      = w_sub[WIDTH];
        o_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SLT: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      OP_SLL: o_result = i_a << w_sh;
      OP_SRL: o_result = i_a >> w_sh;
      OP_SRA: o_result = $unsigned($signed(i_a) >>> w_sh);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/ula_multiciclo.sv
// ula_multiciclo - multi-cycle ALU with start/busy/done handshake.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation without a done pulse
//   bus   : ula_multiciclo_if slave (start/op/operands in; results, Z/C/V, busy, done out)
//
// state | meaning
// IDLE  | waiting for start; latches op and operands when it arrives
// EXEC  | registers result and flags (single-cycle ops, and MUL/DIVU after ITER)
// ITER  | one shift-add (MUL) or restoring shift-subtract (DIVU) step per cycle, WIDTH steps
// DONE  | done pulse; start ignored; returns to IDLE
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  ula_multiciclo_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  ula_state_t       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // MUL: r_hi = partial product high half, r_lo = multiplier shifting out / product low half.
  // DIVU: r_hi = partial remainder, r_lo = dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi_out;
  logic             r_z;
  logic             r_c;
  logic             r_v;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_core_res;
  logic             w_core_c;
  logic             w_core_v;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_div_diff;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_c;
  logic             w_v;

  ula_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_core_res),
    .o_c      (w_core_c),
    .o_v      (w_core_v)
  );

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    // When w_div_ge holds the difference is below r_b, so WIDTH bits suffice.
    // Divide by zero falls out naturally: every step subtracts 0, giving all-ones / A.
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;

    w_res = w_core_res;
    w_hi  = '0;
    w_c   = w_core_c;
    w_v   = w_core_v;
    if (is_iterative(r_op)) begin
      w_res = r_lo;
      w_hi  = r_hi;
      w_c   = 1'b0;
      w_v   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_hi_out <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op    <= bus.ULAControl;
            r_a     <= bus.ScrA;
            r_b     <= bus.ScrB;
            r_hi    <= '0;
            r_lo    <= (bus.ULAControl == OP_MUL) ? bus.ScrB : bus.ScrA;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= is_iterative(bus.ULAControl) ? ITER : EXEC;
          end
        end
        ITER: begin
          if (r_op == OP_MUL) begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
          end
          if (r_cnt == '0) begin
            r_state <= EXEC;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        EXEC: begin
          r_result <= w_res;
          r_hi_out <= w_hi;
          r_z      <= (w_res == '0);
          r_c      <= w_c;
          r_v      <= w_v;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ULAResult = r_result;
  assign bus.ULAHi     = r_hi_out;
  assign bus.Z         = r_z;
  assign bus.C         = r_c;
  assign bus.V         = r_v;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo - directed self-checking bench for ula_multiciclo (WIDTH=8).
module tb_ula_multiciclo;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ula_multiciclo_if #(.WIDTH(W)) u_if ();

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Expected outputs packed as {hi[7:0], result[7:0], Z, C, V}.
  int          m_cnt  = 0;
  bit          m_done = 1'b0;
  bit          m_busy = 1'b0;
  logic [18:0] m_out  = '0;
  logic [18:0] m_pend = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [18:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    int ia, ib, sa, sb, r, h, sh;
    bit c, v;
    logic [7:0] r8;
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = ib % 8;
    r = 0; h = 0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  r = ia & ib;
      4'd1:  r = ia | ib;
      4'd2:  begin r = ia + ib; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'd3:  r = ~(ia | ib);
      4'd6:  begin r = ia - ib; c = (ia >= ib); v = (sa - sb > 127) || (sa - sb < -128); end
      4'd7:  r = (ia < ib) ? 1 : 0;
      4'd8:  r = ia << sh;
      4'd9:  r = ia >> sh;
      4'd10: r = sa >>> sh;
      4'd11: begin r = ia * ib; h = r / 256; end
      4'd12: begin
        if (ib == 0) begin r = 255; h = ia; end
        else begin r = ia / ib; h = ia % ib; end
      end
      default: r = 0;
    endcase
    r8 = 8'(r);
    return {8'(h), r8, (r8 == 8'h00), c, v};
  endfunction

  // Transaction-level model: an accepted start schedules the result to appear
  // with done after a fixed number of cycles; everything else is held.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_done = 1'b0; m_busy = 1'b0; m_out = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_out = m_pend; m_done = 1'b1; m_busy = 1'b0;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (u_if.start) begin
      m_pend = ref_alu(u_if.ULAControl, u_if.ScrA, u_if.ScrB);
      m_busy = 1'b1;
      m_cnt  = (u_if.ULAControl == 4'd11 || u_if.ULAControl == 4'd12) ? W + 1 : 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(u_if.busy),      32'(m_busy));
      check("done",   32'(u_if.done),      32'(m_done));
      check("result", 32'(u_if.ULAResult), 32'(m_out[10:3]));
      check("hi",     32'(u_if.ULAHi),     32'(m_out[18:11]));
      check("Z",      32'(u_if.Z),         32'(m_out[2]));
      check("C",      32'(u_if.C),         32'(m_out[1]));
      check("V",      32'(u_if.V),         32'(m_out[0]));
    end
  end

  // Starts an op in the current (IDLE) cycle, waits for done, returns in the next IDLE cycle.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input bit poke_iter, input bit poke_done);
    int lat, busy_n, exp_lat;
    exp_lat = (op == 4'd11 || op == 4'd12) ? W + 2 : 2;
    u_if.start = 1'b1; u_if.ULAControl = op; u_if.ScrA = a; u_if.ScrB = b;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.ULAControl = poke_iter ? 4'd2 : (op ^ 4'd1);
    u_if.ScrA = ~a;
    u_if.ScrB = a ^ b ^ 8'h5A;
    lat = 1; busy_n = 0;
    while (!u_if.done && lat < 40) begin
      if (poke_iter) u_if.start = (lat == 3);
      busy_n += int'(u_if.busy);
      @(negedge clk);
      lat++;
    end
    u_if.start = 1'b0;
    check("done_latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
    if (poke_done) begin
      u_if.start = 1'b1; u_if.ULAControl = 4'd6; u_if.ScrA = 8'h55; u_if.ScrB = 8'h11;
      @(negedge clk);
      u_if.start = 1'b0;
      check("start_in_done_ignored", 32'(u_if.busy), 32'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] res, input logic [7:0] hi,
                           input logic z, input logic c, input logic v);
    check({name, "_result"}, 32'(u_if.ULAResult), 32'(res));
    check({name, "_hi"},     32'(u_if.ULAHi),     32'(hi));
    check({name, "_flags"},  32'({u_if.Z, u_if.C, u_if.V}), 32'({z, c, v}));
  endtask

  logic [3:0] t_op [14] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9,
                            4'd10, 4'd11, 4'd12, 4'd4, 4'd13, 4'd15};
  logic [7:0] t_a  [14] = '{8'hC3, 8'hA0, 8'h0F, 8'h7F, 8'h10, 8'hFE, 8'h81, 8'h81,
                            8'h7C, 8'h0D, 8'h64, 8'h12, 8'hFF, 8'h34};
  logic [7:0] t_b  [14] = '{8'h5A, 8'h05, 8'hF0, 8'h01, 8'h20, 8'h03, 8'h0B, 8'h07,
                            8'h03, 8'h0B, 8'h64, 8'h34, 8'hFF, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    u_if.start = 1'b0; u_if.ULAControl = '0; u_if.ScrA = '0; u_if.ScrB = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_busy", 32'(u_if.busy), 32'd0);
    check("reset_done", 32'(u_if.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("model_mul_pin", 32'(ref_alu(4'd11, 8'hFF, 8'hFF)), 32'({8'hFE, 8'h01, 3'b000}));
    check("model_divu0_pin", 32'(ref_alu(4'd12, 8'h05, 8'h00)), 32'({8'h05, 8'hFF, 3'b000}));

    do_op(4'd2, 8'hFF, 8'h01, 1'b0, 1'b1);
    check_out("add_ff_01", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    do_op(4'd6, 8'h80, 8'h01, 1'b0, 1'b0);
    check_out("sub_80_01", 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1);
    do_op(4'd7, 8'h03, 8'h05, 1'b0, 1'b0);
    check_out("slt_3_5", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(4'd11, 8'hFF, 8'hFF, 1'b0, 1'b0);
    check_out("mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);

    // Reset during the fourth ITER cycle of a MUL.
    u_if.start = 1'b1; u_if.ULAControl = 4'd11; u_if.ScrA = 8'h0D; u_if.ScrB = 8'h0B;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_out("mid_mul_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("mid_mul_reset_busy", 32'(u_if.busy), 32'd0);
    pulses = 0;
    repeat (12) begin
      pulses += int'(u_if.done);
      @(negedge clk);
    end
    check("mid_mul_reset_no_done", 32'(pulses), 32'd0);

    do_op(4'd12, 8'd200, 8'd7, 1'b0, 1'b0);
    check_out("divu_200_7", 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0);
    do_op(4'd12, 8'd5, 8'd0, 1'b0, 1'b0);
    check_out("divu_5_0", 8'hFF, 8'h05, 1'b0, 1'b0, 1'b0);
    do_op(4'd11, 8'hFF, 8'hFF, 1'b1, 1'b0);
    check_out("mul_with_ignored_add", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
    do_op(4'd10, 8'h90, 8'h02, 1'b0, 1'b0);
    check_out("sra_90_2", 8'hE4, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 1'b0, (i % 3) == 0);
    end

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
